regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised multi-register file for the pipelined CPU core, replacing the fixed 4x16 register file.
- Two combinational read ports with same-cycle write bypass.
- One synchronous write port.
- Per-register pending-write scoreboard, used by the hazard unit to stall on RAW dependences.
- Sequential clear engine: after reset it initialises the array one entry per cycle and reports busy until done.

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 4, number of architectural registers (>=2, need not be a power of two)
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NUM_REGS
RESET_VAL, 0, value written to every register by the clear engine (DATA_W bits)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
rd_addr1  in  ADDR_W  read port 1 address
rd_data1  out  DATA_W  read port 1 data (combinational)
rd_busy1  out  1  pending write outstanding for rd_addr1
rd_addr2  in  ADDR_W  read port 2 address
rd_data2  out  DATA_W  read port 2 data (combinational)
rd_busy2  out  1  pending write outstanding for rd_addr2
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
claim_en  in  1  mark a register as having an in-flight producer (issue stage)
claim_addr  in  ADDR_W  register being claimed
init_busy  out  1  clear engine active; core must stall

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on rising clk.
- FSM states: INIT, RUN.
- Reset at any edge, including mid-INIT or mid-RUN:
  - state <= INIT, clr_cnt <= 0, all pending bits <= 0 at that same edge.
  - Array contents are not touched by reset itself.
- INIT:
  - Each cycle: reg[clr_cnt] <= RESET_VAL, clr_cnt <= clr_cnt+1.
  - When clr_cnt == NUM_REGS-1: go to RUN on that edge.
  - INIT therefore lasts exactly NUM_REGS cycles after reset deasserts.
  - wr_en and claim_en are ignored.
  - rd_data1/2 = RESET_VAL; rd_busy1/2 = 0; init_busy = 1.
- RUN, write:
  - If wr_en and wr_addr < NUM_REGS: reg[wr_addr] <= wr_data at the edge.
  - Out-of-range writes are dropped.
- RUN, read:
  - rd_dataN = wr_data when wr_en && wr_addr == rd_addrN && rd_addrN < NUM_REGS.
  - Otherwise rd_dataN = reg[rd_addrN].
  - Out-of-range read address returns 0.
  - Latency: a write is visible on read ports in the same cycle (bypass) and from the array on the next cycle.
- Scoreboard (RUN only):
  - claim_en sets pending[claim_addr]; a valid wr_en clears pending[wr_addr].
  - Same address, same cycle, claim and write: claim wins, bit ends at 1 (new producer issued).
  - Different addresses: both take effect.
  - Out-of-range claim is ignored.
- rd_busyN:
  - rd_busyN = pending[rd_addrN] && !(wr_en && wr_addr == rd_addrN).
  - The retiring write satisfies the reader this cycle via bypass.
- init_busy: 1 in INIT, 0 in RUN.
- Outputs after the reset edge: init_busy=1, rd_busy1/2=0, rd_data1/2=RESET_VAL.

Optional Feature:
REGFILE_ZERO_REG_EN
- Defined:
  - Register 0 is hardwired to zero: reads of address 0 return 0 regardless of bypass.
  - Writes to 0 are dropped; claims to 0 are ignored, so rd_busyN is never 1 for address 0.
  - Clear engine still sequences NUM_REGS cycles.
- Not defined: register 0 behaves as an ordinary register.

Test Plan:
- Reset sequencing: DATA_W=16, NUM_REGS=4, RESET_VAL=16'hA5A5; hold reset 1 cycle, then release -> init_busy=1 for exactly 4 cycles then 0; all four registers read 16'hA5A5; wr_en during INIT leaves contents unchanged.
- Write/bypass: RUN, wr_en=1, wr_addr=2, wr_data=16'h1234, rd_addr1=2 same cycle -> rd_data1=16'h1234 that cycle; next cycle with wr_en=0 -> rd_data1=16'h1234.
- Dual read: reg1=16'h0011, reg3=16'h0033; rd_addr1=1, rd_addr2=3 -> rd_data1=16'h0011, rd_data2=16'h0033 in the same cycle.
- Scoreboard: claim r1 -> next cycle rd_busy1=1 (rd_addr1=1); write r1 -> rd_busy1=0 that cycle; simultaneous claim+write r1 -> rd_busy1=1 on the following cycle.
- Reset mid-operation: pending r2 set and r3 written 16'hBEEF, then reset asserted 1 cycle -> pending cleared at that edge, INIT restarts from clr_cnt 0, afterwards r3 reads RESET_VAL.
- NUM_REGS=3, ADDR_W=2: write addr 3 with 16'hFFFF -> dropped; read addr 3 -> 0; claim addr 3 -> rd_busy stays 0. With REGFILE_ZERO_REG_EN: write r0=16'h5555 -> r0 reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with write bypass, RAW scoreboard and post-reset clear engine (REGFILE_ZERO_REG_EN hardwires r0 to zero)
module regfile_sb #(
  parameter int DATA_W = 16,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              init_busy
);
  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN = 1'b1;
  localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS-1);
`ifdef REGFILE_ZERO_REG_EN
  localparam logic ZERO_EN = 1'b1;
`else
  localparam logic ZERO_EN = 1'b0;
`endif
  logic                r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [NUM_REGS-1:0] r_pend;
  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic                w_run, w_wr_ok, w_claim_ok;
  logic [ADDR_W-1:0]   w_ra [2];
  logic [DATA_W-1:0]   w_rd [2];
  logic                w_hit [2];
  logic                w_busy [2];
  // an address is usable only if it maps to a real, non-hardwired register
  function automatic logic f_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NR) && !(ZERO_EN && a == '0);
  endfunction
  assign w_run = r_state == ST_RUN;
  assign w_wr_ok = w_run && wr_en && f_ok(wr_addr);
  assign w_claim_ok = w_run && claim_en && f_ok(claim_addr);
  assign w_ra[0] = rd_addr1;
  assign w_ra[1] = rd_addr2;
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_hit[k] = w_wr_ok && wr_addr == w_ra[k];
      w_rd[k] = !w_run ? RESET_VAL : !f_ok(w_ra[k]) ? '0 : w_hit[k] ? wr_data : r_mem[w_ra[k]];
      w_busy[k] = w_run && f_ok(w_ra[k]) && r_pend[w_ra[k]] && !w_hit[k];
    end
  end
  assign rd_data1 = w_rd[0];
  assign rd_data2 = w_rd[1];
  assign rd_busy1 = w_busy[0];
  assign rd_busy2 = w_busy[1];
  assign init_busy = !w_run;
  // a same-cycle claim beats the retiring write: a new producer has issued
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_clr_cnt <= '0;
      r_pend <= '0;
    end else if (!w_run) begin
      r_clr_cnt <= r_clr_cnt == LAST ? '0 : r_clr_cnt + 1'b1;
      r_state <= r_clr_cnt == LAST ? ST_RUN : ST_INIT;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_claim_ok && claim_addr == ADDR_W'(i)) r_pend[i] <= 1'b1;
        else if (w_wr_ok && wr_addr == ADDR_W'(i)) r_pend[i] <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!w_run) r_mem[r_clr_cnt] <= RESET_VAL;
      else if (w_wr_ok) r_mem[wr_addr] <= wr_data;
    end
  end
endmodule
